dram_cmd_sequencer: RTL

- Downstream of the controller's address-translation stage.
- Consumes one decoded read request at a time (bank/row/col) over a valid/ready handshake.
- Drives the DRAM command bus (NOP/ACT/RD/PRE) under an open-page policy, enforcing tRP/tRCD/tCL with down-counters.
- Tracks the open row per bank; returns the read bit on a response strobe.

---
 rtl/dram_defs.sv | 38 +++
 rtl/dram_open_row_table.sv | 42 ++++
 rtl/dram_cmd_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dram_defs.sv
// Shared definitions for the DRAM read-command sequencer: bus encodings,
// sequencer state encoding, default timing and derived field widths.
package dram_defs;

    typedef enum logic [1:0] {
        CMD_NOP = 2'b00,
        CMD_ACT = 2'b01,
        CMD_RD  = 2'b10,
        CMD_PRE = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_PRE_WAIT,
        ST_ACT,
        ST_ACT_WAIT,
        ST_RD,
        ST_RD_WAIT,
        ST_RESP
    } state_e;

    localparam int DEF_DATA_WIDTH   = 1;
    localparam int DEF_NUM_OF_BANKS = 8;
    localparam int DEF_NUM_OF_ROWS  = 128;
    localparam int DEF_NUM_OF_COLS  = 8;
    localparam int DEF_T_RP         = 3;
    localparam int DEF_T_RCD        = 3;
    localparam int DEF_T_CL         = 2;

    // Timing parameters are limited to 1..15, so a 4-bit down-counter suffices.
    localparam int CNT_W = 4;

    localparam int DEF_BANK_W = $clog2(DEF_NUM_OF_BANKS);
    localparam int DEF_ROW_W  = $clog2(DEF_NUM_OF_ROWS);
    localparam int DEF_COL_W  = $clog2(DEF_NUM_OF_COLS);

endpackage

// File: rtl/dram_open_row_table.sv
// Per-bank open-row record {valid,row}. Combinational lookup by bank,
// single write port that either opens a row or closes the bank.
module dram_open_row_table
    import dram_defs::*;
#(
    parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
    parameter int ROW_W        = DEF_ROW_W
) (
    input  logic                            clk,
    input  logic                            rst_b,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] rd_bank_i,
    input  logic [ROW_W-1:0]                rd_row_i,
    output logic                            open_o,
    output logic                            hit_o,
    input  logic                            set_i,
    input  logic                            clr_i,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] wr_bank_i,
    input  logic [ROW_W-1:0]                wr_row_i
);

    logic [NUM_OF_BANKS-1:0] valid_q;
    logic [ROW_W-1:0]        row_q [NUM_OF_BANKS];

    // Entry update: set has priority; only the addressed bank is touched.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                row_q[i] <= '0;
            end
        end else if (set_i) begin
            valid_q[wr_bank_i] <= 1'b1;
            row_q[wr_bank_i]   <= wr_row_i;
        end else if (clr_i) begin
            valid_q[wr_bank_i] <= 1'b0;
        end
    end

    assign open_o = valid_q[rd_bank_i];
    assign hit_o  = valid_q[rd_bank_i] && (row_q[rd_bank_i] == rd_row_i);

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Open-page DRAM read sequencer: one request at a time, PRE/ACT/RD issued
// with tRP/tRCD/tCL spacing from a shared down-counter, registered outputs.
//
//  state       | meaning
//  ------------+----------------------------------------------------------
//  IDLE        | ready for a request
//  PRE         | PRE on the bus, bank closed in the table
//  PRE_WAIT    | NOPs until tRP has elapsed
//  ACT         | ACT on the bus, row recorded as open
//  ACT_WAIT    | NOPs until tRCD has elapsed
//  RD          | RD on the bus
//  RD_WAIT     | NOPs until the data-valid cycle, data captured at its end
//  RESP        | response strobe; also ready, a request here is accepted
module dram_cmd_sequencer
    import dram_defs::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
    parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
    parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_CL         = DEF_T_CL
) (
    input  logic                            clk,
    input  logic                            rst_b,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] req_bank,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  req_row,
    input  logic [$clog2(NUM_OF_COLS)-1:0]  req_col,
    output logic [1:0]                      cmd,
    output logic [$clog2(NUM_OF_BANKS)-1:0] cmd_bank,
    output logic [$clog2(NUM_OF_ROWS)-1:0]  cmd_row,
    output logic [$clog2(NUM_OF_COLS)-1:0]  cmd_col,
    output logic [NUM_OF_BANKS-1:0]         cs,
    input  logic [DATA_WIDTH-1:0]           dram_data_in,
    output logic                            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data
);

    localparam int BANK_W = $clog2(NUM_OF_BANKS);
    localparam int ROW_W  = $clog2(NUM_OF_ROWS);
    localparam int COL_W  = $clog2(NUM_OF_COLS);

    // Counter is loaded on entry to a command state and reaches 0 in the
    // last cycle before the next command may go out.
    localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] CL_LD  = CNT_W'(T_CL - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BANK_W-1:0]       bank_q, bank_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    cmd_e                    cmd_q, cmd_d;
    logic [BANK_W-1:0]       cmd_bank_q, cmd_bank_d;
    logic [ROW_W-1:0]        cmd_row_q, cmd_row_d;
    logic [COL_W-1:0]        cmd_col_q, cmd_col_d;
    logic [NUM_OF_BANKS-1:0] cs_q, cs_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    req_ready_q, req_ready_d;

    logic tbl_open, tbl_hit, tbl_set, tbl_clr;

    dram_open_row_table #(
        .NUM_OF_BANKS (NUM_OF_BANKS),
        .ROW_W        (ROW_W)
    ) u_open_rows (
        .clk       (clk),
        .rst_b     (rst_b),
        .rd_bank_i (req_bank),
        .rd_row_i  (req_row),
        .open_o    (tbl_open),
        .hit_o     (tbl_hit),
        .set_i     (tbl_set),
        .clr_i     (tbl_clr),
        .wr_bank_i (bank_q),
        .wr_row_i  (row_q)
    );

    // Next-state, counter, table writes and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bank_d     = bank_q;
        row_d      = row_q;
        col_d      = col_q;
        rsp_data_d = rsp_data_q;
        tbl_set    = 1'b0;
        tbl_clr    = 1'b0;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (req_valid) begin
                    bank_d = req_bank;
                    row_d  = req_row;
                    col_d  = req_col;
                    if (tbl_hit)       state_d = ST_RD;
                    else if (tbl_open) state_d = ST_PRE;
                    else               state_d = ST_ACT;
                end
            end
            ST_PRE, ST_PRE_WAIT: begin
                tbl_clr = (state_q == ST_PRE);
                if (cnt_q == '0) begin
                    state_d = ST_ACT;
                end else begin
                    state_d = ST_PRE_WAIT;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_ACT, ST_ACT_WAIT: begin
                tbl_set = (state_q == ST_ACT);
                if (cnt_q == '0) begin
                    state_d = ST_RD;
                end else begin
                    state_d = ST_ACT_WAIT;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            // RD_WAIT spans exactly T_CL cycles, so the counter is not
            // consumed in the RD cycle itself.
            ST_RD: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d = dram_data_in;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_d      = CMD_NOP;
        cmd_bank_d = cmd_bank_q;
        cmd_row_d  = cmd_row_q;
        cmd_col_d  = cmd_col_q;
        case (state_d)
            ST_PRE: begin
                cmd_d      = CMD_PRE;
                cmd_bank_d = bank_d;
                cnt_d      = RP_LD;
            end
            ST_ACT: begin
                cmd_d      = CMD_ACT;
                cmd_bank_d = bank_d;
                cmd_row_d  = row_d;
                cnt_d      = RCD_LD;
            end
            ST_RD: begin
                cmd_d      = CMD_RD;
                cmd_bank_d = bank_d;
                cmd_col_d  = col_d;
                cnt_d      = CL_LD;
            end
            default: begin
            end
        endcase

        cs_d = '0;
        if (cmd_d != CMD_NOP) cs_d[bank_d] = 1'b1;
        rsp_valid_d = (state_d == ST_RESP);
        req_ready_d = (state_d == ST_IDLE) || (state_d == ST_RESP);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Request latch, timing counter and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q       <= '0;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cmd_q       <= CMD_NOP;
            cmd_bank_q  <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            cs_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            req_ready_q <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cmd_q       <= cmd_d;
            cmd_bank_q  <= cmd_bank_d;
            cmd_row_q   <= cmd_row_d;
            cmd_col_q   <= cmd_col_d;
            cs_q        <= cs_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_bank  = cmd_bank_q;
    assign cmd_row   = cmd_row_q;
    assign cmd_col   = cmd_col_q;
    assign cs        = cs_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign req_ready = req_ready_q;

endmodule
